mem_arbiter: RTL

//  Sequences the single-ported unified RAM between the datapath's instruction

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the datapath fetch/load-store ports and the unified RAM port.
// "master" is the arbiter's view; "slave" is the view of whatever drives the datapath and RAM sides.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Grants the single-ported RAM to either the data or the instruction port, with data priority,
// a per-grant timeout watchdog and a sticky error flag.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter logic [31:0] BADWORD = 32'hBAD1BAD1
) (
    input logic           CLK,
    input logic           nRST,
    mem_arbiter_if.master bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

    state_t        state_reg;
    logic [TW-1:0] tcnt_reg;
    logic          err_reg;

    logic req_held;
    logic access;
    logic fault;

    // A grant only completes while its requester still holds the request; dropping it aborts quietly.
    always_comb begin
        req_held = 1'b0;
        case (state_reg)
            DGNT:    req_held = bus.dREN | bus.dWEN;
            IGNT:    req_held = bus.iREN;
            default: req_held = 1'b0;
        endcase
        access = req_held && (bus.ramstate == RAM_ACCESS);
        fault  = req_held && !access &&
                 ((bus.ramstate == RAM_ERROR) || (tcnt_reg == TW'(TIMEOUT - 1)));
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0;
        bus.dwait    = 1'b1;
        bus.dload    = 32'h0;
        bus.err      = err_reg;
        case (state_reg)
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (access || fault) begin
                    bus.dwait = 1'b0;
                    if (fault)
                        bus.dload = BADWORD;
                    else if (bus.dREN && !bus.dWEN)
                        bus.dload = bus.ramload;
                end
            end
            IGNT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = 1'b1;
                if (access || fault) begin
                    bus.iwait = 1'b0;
                    bus.iload = fault ? BADWORD : bus.ramload;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            tcnt_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tcnt_reg <= '0;
                    if (bus.dREN || bus.dWEN)
                        state_reg <= DGNT;
                    else if (bus.iREN)
                        state_reg <= IGNT;
                end
                default: begin
                    if (!req_held || access || fault)
                        state_reg <= IDLE;
                    if (tcnt_reg != '1)
                        tcnt_reg <= tcnt_reg + 1'b1;
                    if (fault)
                        err_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule
